// File: rtl/or1200_except_pipe_if.sv
// Signal bundle between the core pipeline and or1200_except_pipe.
// Every signal is a per-cycle level sampled on the rising clock edge. There is no valid/ready handshake.
interface or1200_except_pipe_if #(
    parameter int AW     = 32,
    parameter int TRIG_W = 14
);
    logic [AW-1:0]     if_pc;
    logic              if_insn_valid;
    logic              if_stall;
    logic              id_freeze;
    logic              ex_freeze;
    logic              wb_freeze;
    logic              id_branch_op;
    logic              if_itlbmiss;
    logic              if_ipf;
    logic              if_ibuserr;
    logic              id_illegal;
    logic              id_syscall;
    logic              id_trap;
    logic              ex_align;
    logic              ex_dtlbmiss;
    logic              ex_dpf;
    logic              ex_dbuserr;
    logic              ex_range;
    logic              ex_fpe;
    logic              int_req;
    logic              tick_req;
    logic              sr_iee;
    logic              sr_tee;
    logic              except_flushpipe;
    logic [TRIG_W-1:0] except_trig;
    logic              except_pending;
    logic [AW-1:0]     id_pc;
    logic [AW-1:0]     ex_pc;
    logic [AW-1:0]     wb_pc;
    logic [AW-1:0]     dl_pc;
    logic              ex_dslot;
    logic              delayed1_ex_dslot;
    logic              delayed2_ex_dslot;

    modport master (
        output if_pc, if_insn_valid, if_stall, id_freeze, ex_freeze, wb_freeze, id_branch_op,
               if_itlbmiss, if_ipf, if_ibuserr, id_illegal, id_syscall, id_trap,
               ex_align, ex_dtlbmiss, ex_dpf, ex_dbuserr, ex_range, ex_fpe,
               int_req, tick_req, sr_iee, sr_tee, except_flushpipe,
        input  except_trig, except_pending, id_pc, ex_pc, wb_pc, dl_pc,
               ex_dslot, delayed1_ex_dslot, delayed2_ex_dslot
    );

    modport slave (
        input  if_pc, if_insn_valid, if_stall, id_freeze, ex_freeze, wb_freeze, id_branch_op,
               if_itlbmiss, if_ipf, if_ibuserr, id_illegal, id_syscall, id_trap,
               ex_align, ex_dtlbmiss, ex_dpf, ex_dbuserr, ex_range, ex_fpe,
               int_req, tick_req, sr_iee, sr_tee, except_flushpipe,
        output except_trig, except_pending, id_pc, ex_pc, wb_pc, dl_pc,
               ex_dslot, delayed1_ex_dslot, delayed2_ex_dslot
    );
endinterface

// File: rtl/or1200_except_pipe.sv
// Tracks exception flags, PCs and delay-slot history through ID/EX/WB for the exception FSM.
// Define OR1200_EXCEPT_PIPE_FPU_EN to capture ex_fpe into except_trig[2].
module or1200_except_pipe #(
    parameter int AW     = 32,
    parameter int TRIG_W = 14
) (
    input logic               clk,
    input logic               rst_n,
    or1200_except_pipe_if.slave pif
);
    typedef struct packed {
        logic itlbmiss;
        logic ipf;
        logic ibuserr;
        logic illegal;
        logic syscall;
        logic trap;
    } id_flags_t;

    // Field order matches except_trig[13:3]
    typedef struct packed {
        logic itlbmiss;
        logic ipf;
        logic ibuserr;
        logic illegal;
        logic align;
        logic dtlbmiss;
        logic trap;
        logic syscall;
        logic dpf;
        logic dbuserr;
        logic range;
    } ex_flags_t;

    logic [AW-1:0] id_pc_q, ex_pc_q, wb_pc_q, dl_pc_q;
    id_flags_t     id_flags, id_now;
    ex_flags_t     ex_flags, ex_base, ex_next;
    logic          ex_dslot_q, dslot1_q, dslot2_q;
    logic          int_q, tick_q;
    logic          fpe_bit;
    logic [TRIG_W-1:0] trig_c;

    wire flush = pif.except_flushpipe;

    // ID-stage causes of the instruction currently sitting in ID, including this cycle's sources
    always_comb begin
        id_now         = id_flags;
        id_now.illegal = id_flags.illegal | pif.id_illegal;
        id_now.syscall = id_flags.syscall | pif.id_syscall;
        id_now.trap    = id_flags.trap    | pif.id_trap;
    end

    // EX flags: hold while frozen, take ID on advance, bubble otherwise; EX sources always accumulate
    always_comb begin
        ex_base = '0;
        if (pif.ex_freeze) begin
            ex_base = ex_flags;
        end else if (!pif.id_freeze) begin
            ex_base.itlbmiss = id_now.itlbmiss;
            ex_base.ipf      = id_now.ipf;
            ex_base.ibuserr  = id_now.ibuserr;
            ex_base.illegal  = id_now.illegal;
            ex_base.syscall  = id_now.syscall;
            ex_base.trap     = id_now.trap;
        end
        ex_next          = ex_base;
        ex_next.align    = ex_base.align    | pif.ex_align;
        ex_next.dtlbmiss = ex_base.dtlbmiss | pif.ex_dtlbmiss;
        ex_next.dpf      = ex_base.dpf      | pif.ex_dpf;
        ex_next.dbuserr  = ex_base.dbuserr  | pif.ex_dbuserr;
        ex_next.range    = ex_base.range    | pif.ex_range;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_pc_q  <= '0;
            id_flags <= '0;
        end else if (flush) begin
            id_flags <= '0;
        end else if (!pif.id_freeze) begin
            if (!pif.if_stall) begin
                id_pc_q  <= pif.if_pc;
                id_flags <= id_flags_t'({pif.if_itlbmiss, pif.if_ipf, pif.if_ibuserr, 3'b000}
                                        & {6{pif.if_insn_valid}});
            end else begin
                id_flags <= '0;
            end
        end else begin
            id_flags <= id_now;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_pc_q    <= '0;
            dl_pc_q    <= '0;
            ex_flags   <= '0;
            ex_dslot_q <= 1'b0;
            dslot1_q   <= 1'b0;
            dslot2_q   <= 1'b0;
        end else if (flush) begin
            ex_flags   <= '0;
            ex_dslot_q <= 1'b0;
            dslot1_q   <= 1'b0;
            dslot2_q   <= 1'b0;
        end else begin
            ex_flags <= ex_next;
            if (!pif.ex_freeze) begin
                dslot1_q <= ex_dslot_q;
                dslot2_q <= dslot1_q;
                if (!pif.id_freeze) begin
                    ex_pc_q    <= id_pc_q;
                    dl_pc_q    <= ex_pc_q;
                    ex_dslot_q <= pif.id_branch_op;
                end else begin
                    ex_dslot_q <= 1'b0;
                end
            end
        end
    end

`ifdef OR1200_EXCEPT_PIPE_FPU_EN
    logic ex_fpe_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ex_fpe_q <= 1'b0;
        else if (flush)
            ex_fpe_q <= 1'b0;
        else
            ex_fpe_q <= (pif.ex_freeze & ex_fpe_q) | pif.ex_fpe;
    end
    assign fpe_bit = ex_fpe_q;
`else
    logic unused_fpe;
    assign unused_fpe = pif.ex_fpe;
    assign fpe_bit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wb_pc_q <= '0;
        else if (!flush && !pif.wb_freeze)
            wb_pc_q <= ex_pc_q;
    end

    // Interrupt levels are sampled once; no edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_q  <= 1'b0;
            tick_q <= 1'b0;
        end else if (flush) begin
            int_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            int_q  <= pif.int_req;
            tick_q <= pif.tick_req;
        end
    end

    assign trig_c = flush ? '0 : {ex_flags, fpe_bit, int_q & pif.sr_iee, tick_q & pif.sr_tee};

    assign pif.except_trig       = trig_c;
    assign pif.except_pending    = |trig_c;
    assign pif.id_pc             = id_pc_q;
    assign pif.ex_pc             = ex_pc_q;
    assign pif.wb_pc             = wb_pc_q;
    assign pif.dl_pc             = dl_pc_q;
    assign pif.ex_dslot          = ex_dslot_q;
    assign pif.delayed1_ex_dslot = dslot1_q;
    assign pif.delayed2_ex_dslot = dslot2_q;
endmodule

// File: tb/tb_or1200_except_pipe.sv
// Scoreboard bench for or1200_except_pipe: randomized stimulus against an instruction-slot model,
// plus directed scenarios; honours OR1200_EXCEPT_PIPE_FPU_EN like the design.
module tb_or1200_except_pipe;
  localparam int AW = 32;
  localparam int TW = 14;

  // Cause vectors use except_trig bit positions directly
  localparam logic [13:0] IF_M = 14'h3800;
  localparam logic [13:0] ID_M = 14'h04C0;
`ifdef OR1200_EXCEPT_PIPE_FPU_EN
  localparam logic [13:0] EX_M = 14'h033C;
`else
  localparam logic [13:0] EX_M = 14'h0338;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic        valid, stall, idf, exf, wbf, br;
    logic [13:0] src;
    logic        intr, tick, iee, tee, flush;
  } stim_t;

  typedef struct packed {
    logic [13:0] trig;
    logic        pend;
    logic [31:0] id_pc, ex_pc, wb_pc, dl_pc;
    logic        ds, d1, d2;
  } obs_t;

  localparam int W = $bits(obs_t);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  or1200_except_pipe_if #(.AW(AW), .TRIG_W(TW)) pif();
  or1200_except_pipe #(.AW(AW), .TRIG_W(TW)) dut (.clk(clk), .rst_n(rst_n), .pif(pif));

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Instruction slots of the reference model
  logic [31:0] m_id_pc, m_ex_pc, m_wb_pc, m_dl_pc;
  logic [13:0] m_id_c, m_ex_c;
  logic        m_ex_ds, m_d1, m_d2, m_int, m_tick;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_obs(input string tag, input obs_t act, input obs_t exp);
    chk({tag, "_trig"}, 32'(act.trig), 32'(exp.trig));
    chk({tag, "_pending"}, 32'(act.pend), 32'(exp.pend));
    chk({tag, "_id_pc"}, act.id_pc, exp.id_pc);
    chk({tag, "_ex_pc"}, act.ex_pc, exp.ex_pc);
    chk({tag, "_wb_pc"}, act.wb_pc, exp.wb_pc);
    chk({tag, "_dl_pc"}, act.dl_pc, exp.dl_pc);
    chk({tag, "_dslots"}, {29'd0, act.ds, act.d1, act.d2}, {29'd0, exp.ds, exp.d1, exp.d2});
  endtask

  function automatic obs_t dut_obs();
    obs_t o;
    o.trig  = pif.except_trig;
    o.pend  = pif.except_pending;
    o.id_pc = pif.id_pc;
    o.ex_pc = pif.ex_pc;
    o.wb_pc = pif.wb_pc;
    o.dl_pc = pif.dl_pc;
    o.ds    = pif.ex_dslot;
    o.d1    = pif.delayed1_ex_dslot;
    o.d2    = pif.delayed2_ex_dslot;
    return o;
  endfunction

  task automatic apply(input stim_t s);
    pif.if_pc            = s.pc;
    pif.if_insn_valid    = s.valid;
    pif.if_stall         = s.stall;
    pif.id_freeze        = s.idf;
    pif.ex_freeze        = s.exf;
    pif.wb_freeze        = s.wbf;
    pif.id_branch_op     = s.br;
    pif.if_itlbmiss      = s.src[13];
    pif.if_ipf           = s.src[12];
    pif.if_ibuserr       = s.src[11];
    pif.id_illegal       = s.src[10];
    pif.ex_align         = s.src[9];
    pif.ex_dtlbmiss      = s.src[8];
    pif.id_trap          = s.src[7];
    pif.id_syscall       = s.src[6];
    pif.ex_dpf           = s.src[5];
    pif.ex_dbuserr       = s.src[4];
    pif.ex_range         = s.src[3];
    pif.ex_fpe           = s.src[2];
    pif.int_req          = s.intr;
    pif.tick_req         = s.tick;
    pif.sr_iee           = s.iee;
    pif.sr_tee           = s.tee;
    pif.except_flushpipe = s.flush;
  endtask

  function automatic stim_t mk(input logic [31:0] pc);
    stim_t s;
    s = '0;
    s.pc = pc;
    s.valid = 1'b1;
    return s;
  endfunction

  function automatic stim_t rnd_stim();
    stim_t s;
    s = '0;
    s.pc    = $urandom & 32'hFFFF_FFFC;
    s.valid = $urandom_range(0, 7) != 0;
    s.stall = $urandom_range(0, 5) == 0;
    s.exf   = $urandom_range(0, 4) == 0;
    s.idf   = s.exf ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
    s.wbf   = $urandom_range(0, 5) == 0;
    s.br    = $urandom_range(0, 3) == 0;
    for (int b = 2; b < 14; b++) s.src[b] = $urandom_range(0, 9) == 0;
    s.intr  = $urandom_range(0, 3) == 0;
    s.tick  = $urandom_range(0, 3) == 0;
    s.iee   = $urandom_range(0, 1) == 1;
    s.tee   = $urandom_range(0, 1) == 1;
    s.flush = $urandom_range(0, 19) == 0;
    return s;
  endfunction

  task automatic model_reset();
    m_id_pc = '0; m_ex_pc = '0; m_wb_pc = '0; m_dl_pc = '0;
    m_id_c = '0; m_ex_c = '0;
    m_ex_ds = 1'b0; m_d1 = 1'b0; m_d2 = 1'b0; m_int = 1'b0; m_tick = 1'b0;
  endtask

  function automatic obs_t model_expect(input stim_t s);
    obs_t e;
    e.trig  = s.flush ? 14'h0 : (m_ex_c | {12'h0, m_int & s.iee, m_tick & s.tee});
    e.pend  = |e.trig;
    e.id_pc = m_id_pc;
    e.ex_pc = m_ex_pc;
    e.wb_pc = m_wb_pc;
    e.dl_pc = m_dl_pc;
    e.ds    = m_ex_ds;
    e.d1    = m_d1;
    e.d2    = m_d2;
    return e;
  endfunction

  // Move instruction slots along one clock edge
  task automatic model_step(input stim_t s);
    logic [13:0] id_src, ex_src;
    id_src = s.src & ID_M;
    ex_src = s.src & EX_M;
    if (s.flush) begin
      m_id_c = '0; m_ex_c = '0;
      m_ex_ds = 1'b0; m_d1 = 1'b0; m_d2 = 1'b0; m_int = 1'b0; m_tick = 1'b0;
      return;
    end
    if (!s.wbf) m_wb_pc = m_ex_pc;
    if (!s.exf) begin
      m_d2 = m_d1;
      m_d1 = m_ex_ds;
      if (!s.idf) begin
        m_dl_pc = m_ex_pc;
        m_ex_pc = m_id_pc;
        m_ex_c  = m_id_c | id_src;
        m_ex_ds = s.br;
      end else begin
        m_ex_c  = '0;
        m_ex_ds = 1'b0;
      end
    end
    m_ex_c = m_ex_c | ex_src;
    if (!s.idf) begin
      if (!s.stall) begin
        m_id_pc = s.pc;
        m_id_c  = s.valid ? (s.src & IF_M) : 14'h0;
      end else begin
        m_id_c = '0;
      end
    end else begin
      m_id_c = m_id_c | id_src;
    end
    m_int  = s.intr;
    m_tick = s.tick;
  endtask

  // Issue one cycle: drive, queue the expected view, advance the model, cross the edge
  task automatic cycle(input stim_t s);
    apply(s);
    exp_q.push_back(W'(model_expect(s)));
    model_step(s);
    @(posedge clk);
    #1;
  endtask

  obs_t mon_e;
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      mon_e = obs_t'(exp_q.pop_front());
      chk_obs("sb", dut_obs(), mon_e);
    end
  end

  initial begin
    stim_t s;
    obs_t zero_o;
    zero_o = '0;
    model_reset();
    apply(mk(32'h0));
    #1;
    chk_obs("reset", dut_obs(), zero_o);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // IF page fault reaches the trigger two edges later
    s = mk(32'h100); s.src[12] = 1'b1;
    cycle(s);
    cycle(mk(32'h104));
    chk("ipf_ex_pc", pif.ex_pc, 32'h100);
    chk("ipf_trig", 32'(pif.except_trig), 32'h1000);

    // Branch at 0x200 marks its successor as delay slot
    cycle(mk(32'h200));
    s = mk(32'h204); s.br = 1'b1;
    cycle(s);
    chk("dslot_ex_pc", pif.ex_pc, 32'h200);
    chk("dslot_ex_dslot", 32'(pif.ex_dslot), 32'h1);
    cycle(mk(32'h208));
    chk("dslot_d1", 32'(pif.delayed1_ex_dslot), 32'h1);
    chk("dslot_dl_pc", pif.dl_pc, 32'h200);
    chk("dslot_ex_pc2", pif.ex_pc, 32'h204);

    // Alignment fault stays asserted while EX is frozen
    for (int i = 0; i < 3; i++) begin
      s = mk(32'h20C); s.exf = 1'b1; s.idf = 1'b1; s.src[9] = (i == 0);
      cycle(s);
      chk("align_sticky", 32'(pif.except_trig), 32'h0200);
    end

    // Flush masks the trigger at once and clears the flags on the edge
    cycle(mk(32'h210));
    s = mk(32'h214); s.exf = 1'b1; s.idf = 1'b1; s.src[5] = 1'b1;
    cycle(s);
    chk("dpf_trig", 32'(pif.except_trig), 32'h0020);
    s = mk(32'h214); s.flush = 1'b1;
    apply(s);
    exp_q.push_back(W'(model_expect(s)));
    #1;
    chk("flush_same_cycle", 32'(pif.except_trig), 32'h0);
    model_step(s);
    @(posedge clk);
    #1;
    apply(mk(32'h214));
    #1;
    chk("flush_after_edge", 32'(pif.except_trig), 32'h0);

    // Interrupt gated by sr_iee
    s = mk(32'h300); s.intr = 1'b1;
    cycle(s);
    chk("int_masked", 32'(pif.except_trig), 32'h0);
    s.iee = 1'b1;
    cycle(s);
    chk("int_enabled", 32'(pif.except_trig), 32'h0002);

    // FPE only reaches the trigger when the FPU option is built in
    cycle(mk(32'h304));
    s = mk(32'h308); s.exf = 1'b1; s.idf = 1'b1; s.src[2] = 1'b1;
    cycle(s);
`ifdef OR1200_EXCEPT_PIPE_FPU_EN
    chk("fpe_trig", 32'(pif.except_trig), 32'h0004);
`else
    chk("fpe_trig", 32'(pif.except_trig), 32'h0);
`endif

    for (int i = 0; i < 400; i++) cycle(rnd_stim());

    // Asynchronous reset mid-run clears everything immediately
    s = mk(32'h0); s.iee = 1'b1; s.tee = 1'b1;
    apply(s);
    rst_n = 1'b0;
    #1;
    chk_obs("async_reset", dut_obs(), zero_o);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++) cycle(rnd_stim());

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
